// File: rtl/pipelined_carry_skip_adder.sv
// Purpose: pipelined carry-skip adder/subtractor, one BLOCK_SIZE-bit carry-skip block per stage.
// Latency: NUM_BLOCKS cycles from the accepting edge to out_valid; one operation per cycle.
// Backpressure: a result held with out_ready low stalls every stage and drops in_ready.
//
// Ports:
//   clk, rst_n            single rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operation handshake (A, B, Cin, sub captured on transfer)
//   A, B                  operands; sub=0 gives A+B+Cin, sub=1 gives A-B (Cin ignored)
//   out_valid / out_ready result handshake
//   Sout, Cout, ovf       sum modulo 2^OPERAND_SIZE, carry out of MSB, signed overflow
module pipelined_carry_skip_adder #(
    parameter int OPERAND_SIZE = 32,
    parameter int BLOCK_SIZE   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPERAND_SIZE-1:0] A,
    input  logic [OPERAND_SIZE-1:0] B,
    input  logic                    Cin,
    input  logic                    sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OPERAND_SIZE-1:0] Sout,
    output logic                    Cout,
    output logic                    ovf
);

    // Guarded copies so a bad parameter set reaches the elaboration error
    // below instead of a divide-by-zero.
    localparam int SAFE_BS    = (BLOCK_SIZE < 1) ? 1 : BLOCK_SIZE;
    localparam int NUM_BLOCKS = OPERAND_SIZE / SAFE_BS;

    generate
        if (BLOCK_SIZE < 1) begin : g_bad_block_size
            $error("pipelined_carry_skip_adder: BLOCK_SIZE must be at least 1");
        end else if ((OPERAND_SIZE % BLOCK_SIZE) != 0) begin : g_bad_operand_size
            $error("pipelined_carry_skip_adder: OPERAND_SIZE must be a multiple of BLOCK_SIZE");
        end
    endgenerate

    // Level k holds the state entering stage k; level NUM_BLOCKS is the
    // output register. Operands are kept full width and B is stored already
    // inverted for subtraction, so every stage is a plain adder block.
    logic                    r_vld   [0:NUM_BLOCKS];
    logic                    r_carry [0:NUM_BLOCKS];
    logic [OPERAND_SIZE-1:0] r_sum   [0:NUM_BLOCKS];
    logic [OPERAND_SIZE-1:0] r_a     [0:NUM_BLOCKS-1];
    logic [OPERAND_SIZE-1:0] r_b     [0:NUM_BLOCKS-1];
    logic                    r_ovf;

    logic [OPERAND_SIZE-1:0] w_nsum   [0:NUM_BLOCKS-1];
    logic                    w_ncarry [0:NUM_BLOCKS-1];
    logic [SAFE_BS:0]        w_chain  [0:NUM_BLOCKS-1];
    logic [SAFE_BS-1:0]      w_prop   [0:NUM_BLOCKS-1];
    logic                    w_stall;
    logic                    w_ovf;

    assign w_stall   = r_vld[NUM_BLOCKS] & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_vld[NUM_BLOCKS];
    assign Sout      = r_sum[NUM_BLOCKS];
    assign Cout      = r_carry[NUM_BLOCKS];
    assign ovf       = r_ovf;

    // Stage k: ripple chain over its bits, then the skip mux forwards the
    // block carry-in straight to carry-out when every bit propagates.
    always_comb begin
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            w_nsum[k]     = r_sum[k];
            w_chain[k]    = '0;
            w_prop[k]     = '0;
            w_chain[k][0] = r_carry[k];
            for (int i = 0; i < SAFE_BS; i++) begin
                w_prop[k][i]              = r_a[k][k*SAFE_BS+i] ^ r_b[k][k*SAFE_BS+i];
                w_nsum[k][k*SAFE_BS+i]    = w_prop[k][i] ^ w_chain[k][i];
                w_chain[k][i+1]           = (r_a[k][k*SAFE_BS+i] & r_b[k][k*SAFE_BS+i])
                                          | (w_prop[k][i] & w_chain[k][i]);
            end
            w_ncarry[k] = (&w_prop[k]) ? r_carry[k] : w_chain[k][SAFE_BS];
        end
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign w_ovf = w_chain[NUM_BLOCKS-1][SAFE_BS-1] ^ w_ncarry[NUM_BLOCKS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NUM_BLOCKS; k++) begin
                r_vld[k]   <= 1'b0;
                r_carry[k] <= 1'b0;
                r_sum[k]   <= '0;
            end
            for (int k = 0; k < NUM_BLOCKS; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
            r_ovf <= 1'b0;
        end else if (!w_stall) begin
            // in_ready is 1 here, so in_valid alone marks a transfer.
            r_vld[0] <= in_valid;
            r_sum[0] <= '0;
            if (in_valid) begin
                r_a[0]     <= A;
                r_b[0]     <= sub ? ~B : B;
                r_carry[0] <= sub ? 1'b1 : Cin;
            end
            for (int k = 0; k < NUM_BLOCKS; k++) begin
                r_vld[k+1]   <= r_vld[k];
                r_sum[k+1]   <= w_nsum[k];
                r_carry[k+1] <= w_ncarry[k];
            end
            for (int k = 1; k < NUM_BLOCKS; k++) begin
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
            end
            r_ovf <= w_ovf;
        end
    end

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Purpose: scoreboard bench for pipelined_carry_skip_adder (16-bit operands, 4-bit blocks).
// Latency: expects results 4 cycles after acceptance when the output is not stalled.
// Backpressure: drives random out_ready and checks held results and in_ready during stalls.
module tb_pipelined_carry_skip_adder;

    localparam int W   = 16;
    localparam int BS  = 4;
    localparam int LAT = W / BS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] Sout;
    logic         Cout;
    logic         ovf;

    pipelined_carry_skip_adder #(.OPERAND_SIZE(W), .BLOCK_SIZE(BS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sout(Sout), .Cout(Cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_out = 0;
    bit   chk_lat = 1'b0;
    res_t exp_q[$];
    int   acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic; signed overflow means the true
    // signed result does not fit in W bits.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb);
        int   ua, ub, sa, sbv, tot, sres;
        res_t r;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (sb) begin
            tot  = ua - ub + 65536;
            sres = sa - sbv;
        end else begin
            tot  = ua + ub + int'(ci);
            sres = sa + sbv + int'(ci);
        end
        r.s = tot[W-1:0];
        r.c = (tot >= 65536);
        r.o = (sres > 32767) || (sres < -32768);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus: drive after the rising edge, then at the falling
    // edge record the operation if the coming edge will transfer it.
    task automatic drive(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit ci, input bit s, input bit ordy, output bit acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        A         = a;
        B         = b;
        Cin       = ci;
        sub       = s;
        out_ready = ordy;
        @(negedge clk);
        acc = v && in_ready && rst_n;
        if (acc) begin
            exp_q.push_back(model(a, b, ci, s));
            acc_q.push_back(cyc + 1);
            n_acc++;
        end
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input bit ci, input bit s);
        bit acc;
        drive(1'b1, a, b, ci, s, 1'b1, acc);
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        repeat (n) drive(1'b0, '0, '0, 1'b0, 1'b0, ordy, acc);
    endtask

    // Monitor: pops the scoreboard on every output transfer, and checks that
    // a stalled result stays put.
    res_t         m_exp;
    int           m_acc;
    logic         m_hold = 1'b0;
    logic [W-1:0] m_s;
    logic         m_c;
    logic         m_o;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_hold = 1'b0;
        end else begin
            if (m_hold)
                chk("hold_stable", {13'd0, out_valid, Sout, Cout, ovf}, {13'd0, 1'b1, m_s, m_c, m_o});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got Sout=0x%0h with nothing pending (cycle %0d)", Sout, cyc);
                end else begin
                    m_exp = exp_q.pop_front();
                    m_acc = acc_q.pop_front();
                    chk("result", {14'd0, Sout, Cout, ovf}, {14'd0, m_exp.s, m_exp.c, m_exp.o});
                    if (chk_lat) chk("latency", cyc - m_acc, LAT);
                    n_out++;
                end
            end
            m_hold = out_valid && !out_ready;
            m_s    = Sout;
            m_c    = Cout;
            m_o    = ovf;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d results pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bit acc;
        int n_rand;
        int flushed;
        logic [W-1:0] ra, rb;

        // Reset state, checked while rst_n is still low.
        #12;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sout", Sout, 0);
        chk("reset_cout", Cout, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Full skip path, first op after reset, latency checked.
        chk_lat = 1'b1;
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle(LAT + 2, 1'b1);

        // Subtraction corners: signed overflow, and borrow.
        op(16'h8000, 16'h0001, 1'b1, 1'b1);
        op(16'h0000, 16'h0001, 1'b0, 1'b1);
        idle(LAT + 2, 1'b1);
        chk_lat = 1'b0;

        // Back-to-back ops, then hold the first result for two cycles.
        op(16'h1234, 16'h1111, 1'b0, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
            seen = out_valid;
        end
        chk("stall_first_seen", seen, 1);
        if (seen) begin
            chk("stall_in_ready_1", in_ready, 0);
            chk("stall_sout_1", Sout, 16'h2345);
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
            chk("stall_in_ready_2", in_ready, 0);
            chk("stall_sout_2", Sout, 16'h2345);
        end
        idle(LAT + 4, 1'b1);
        chk("directed_drained", exp_q.size(), 0);

        // Reset mid-flight discards both ops.
        op(16'h1111, 16'h2222, 1'b0, 1'b0);
        op(16'h3333, 16'h4444, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_sout", Sout, 0);
        chk("midreset_cout", Cout, 0);
        chk("midreset_ovf", ovf, 0);
        chk("midreset_in_ready", in_ready, 1);
        flushed = exp_q.size();
        n_acc  -= flushed;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(LAT + 6, 1'b1);
        chk_lat = 1'b1;
        op(16'h0002, 16'h0003, 1'b0, 1'b0);
        idle(LAT + 2, 1'b1);
        chk_lat = 1'b0;

        // Random traffic with random backpressure.
        n_rand = 0;
        for (int i = 0; i < 40000 && n_rand < 10000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 7) == 0) ra = ~rb;
            drive($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
            if (acc) n_rand++;
        end
        chk("random_ops_accepted", n_rand, 10000);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1, 1'b1);
        chk("final_drained", exp_q.size(), 0);
        chk("results_vs_accepted", n_out, n_acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
